// File: rtl/cmsdk_mcu_ahb_slot_mux_pkg.sv
// Shared encodings and constants for the AHB slot multiplexer and its default slave.
package cmsdk_mcu_ahb_slot_mux_pkg;

    localparam int MAX_SLOTS  = 16;
    localparam int SLOT_IDX_W = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

endpackage

// File: rtl/cmsdk_mcu_ahb_default_slave.sv
// Two-cycle AHB ERROR responder for active transfers that hit no mapped slot.
module cmsdk_mcu_ahb_default_slave
    import cmsdk_mcu_ahb_slot_mux_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic hready_i,
    output logic hreadyout_o,
    output logic hresp_o
);

    ds_state_e state_q, state_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= DS_IDLE;
        else       state_q <= state_d;
    end

    // start_i is already qualified with HREADY, so an error accepted in ERR2 chains straight into ERR1
    always_comb begin
        state_d = state_q;
        case (state_q)
            DS_IDLE: if (start_i) state_d = DS_ERR1;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: if (hready_i) state_d = start_i ? DS_ERR1 : DS_IDLE;
            default: state_d = DS_IDLE;
        endcase
    end

    assign hreadyout_o = (state_q != DS_ERR1);
    assign hresp_o     = (state_q != DS_IDLE);

endmodule

// File: rtl/cmsdk_mcu_ahb_slot_mux.sv
// AHB slot decoder and response multiplexer with a default slave and sticky decode-error capture.
module cmsdk_mcu_ahb_slot_mux
    import cmsdk_mcu_ahb_slot_mux_pkg::*;
#(
    parameter int                   NUM_SLOTS   = 11,
    parameter logic [31:0]          BASEADDR    = 32'h4000_0000,
    parameter int                   SLOT_SHIFT  = 12,
    parameter logic [MAX_SLOTS-1:0] SLOT_ENABLE = 16'hFFFF
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSEL,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HREADY,
    output logic [NUM_SLOTS-1:0]    slv_hsel,
    input  logic [NUM_SLOTS-1:0]    slv_hreadyout,
    input  logic [32*NUM_SLOTS-1:0] slv_hrdata,
    input  logic [NUM_SLOTS-1:0]    slv_hresp,
    output logic                    HREADYOUT,
    output logic [31:0]             HRDATA,
    output logic                    HRESP,
    output logic                    err_valid,
    output logic [31:0]             err_addr,
    input  logic                    err_clr
);

    localparam logic [SLOT_IDX_W:0] NSLOTS_W = (SLOT_IDX_W+1)'(NUM_SLOTS);

    logic [SLOT_IDX_W-1:0] slot_idx;
    logic                  region_hit, hit, trans_active, err_req;

    assign trans_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    assign slot_idx     = HADDR[SLOT_SHIFT+3:SLOT_SHIFT];
    assign region_hit   = HSEL && (HADDR[31:SLOT_SHIFT+4] == BASEADDR[31:SLOT_SHIFT+4]);
    assign hit          = region_hit && ({1'b0, slot_idx} < NSLOTS_W) && SLOT_ENABLE[slot_idx];
    assign err_req      = HSEL && !hit && trans_active && HREADY;

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_hsel
        assign slv_hsel[k] = hit && (slot_idx == SLOT_IDX_W'(k));
    end

    logic                  dp_slot_q, dp_slot_d, dp_def_q, dp_def_d;
    logic [SLOT_IDX_W-1:0] dp_idx_q, dp_idx_d;

    always_comb begin
        dp_slot_d = dp_slot_q;
        dp_def_d  = dp_def_q;
        dp_idx_d  = dp_idx_q;
        if (HREADY) begin
            dp_slot_d = hit;
            dp_def_d  = err_req;
            dp_idx_d  = hit ? slot_idx : '0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_slot_q <= 1'b0;
            dp_def_q  <= 1'b0;
            dp_idx_q  <= '0;
        end else begin
            dp_slot_q <= dp_slot_d;
            dp_def_q  <= dp_def_d;
            dp_idx_q  <= dp_idx_d;
        end
    end

    logic ds_hreadyout, ds_hresp;

    cmsdk_mcu_ahb_default_slave u_default_slave (
        .clk_i       (HCLK),
        .rst_i       (HRESET),
        .start_i     (err_req),
        .hready_i    (HREADY),
        .hreadyout_o (ds_hreadyout),
        .hresp_o     (ds_hresp)
    );

    logic [NUM_SLOTS-1:0][31:0] rdata_arr;
    assign rdata_arr = slv_hrdata;

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = 32'h0;
        if (dp_slot_q) begin
            HREADYOUT = slv_hreadyout[dp_idx_q];
            HRESP     = slv_hresp[dp_idx_q];
            HRDATA    = rdata_arr[dp_idx_q];
        end else if (dp_def_q) begin
            HREADYOUT = ds_hreadyout;
            HRESP     = ds_hresp;
        end
    end

    // A clear arriving with a new error lets the new error re-arm the flag with its own address
    logic        err_valid_q, err_valid_d, err_cap;
    logic [31:0] err_addr_q, err_addr_d;

    assign err_cap = err_req && (!err_valid_q || err_clr);

    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        if (err_cap) begin
            err_valid_d = 1'b1;
            err_addr_d  = HADDR;
        end else if (err_clr) begin
            err_valid_d = 1'b0;
            err_addr_d  = 32'h0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= 32'h0;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_cmsdk_mcu_ahb_slot_mux.sv
// Directed bench for the slot mux: default build plus a copy with slot 2 disabled.
module tb_cmsdk_mcu_ahb_slot_mux;
    localparam int NS = 11;

    logic          HCLK, HRESET, HSEL, err_clr;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic [NS-1:0] slv_hreadyout, slv_hresp;
    logic [32*NS-1:0] slv_hrdata;

    logic [NS-1:0] hsel1, hsel2;
    logic          rdy1, rdy2, resp1, resp2, ev1, ev2;
    logic [31:0]   rd1, rd2, ea1, ea2;

    int n_cmp = 0;
    int n_err = 0;

    cmsdk_mcu_ahb_slot_mux #(.NUM_SLOTS(NS)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HREADY(rdy1), .slv_hsel(hsel1), .slv_hreadyout(slv_hreadyout),
        .slv_hrdata(slv_hrdata), .slv_hresp(slv_hresp), .HREADYOUT(rdy1),
        .HRDATA(rd1), .HRESP(resp1), .err_valid(ev1), .err_addr(ea1), .err_clr(err_clr)
    );

    cmsdk_mcu_ahb_slot_mux #(.NUM_SLOTS(NS), .SLOT_ENABLE(16'hFFFB)) dut_en (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HREADY(rdy2), .slv_hsel(hsel2), .slv_hreadyout(slv_hreadyout),
        .slv_hrdata(slv_hrdata), .slv_hresp(slv_hresp), .HREADYOUT(rdy2),
        .HRDATA(rd2), .HRESP(resp2), .err_valid(ev2), .err_addr(ea2), .err_clr(err_clr)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic sample();
        @(negedge HCLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; err_clr = 1'b0;
        slv_hreadyout = '1; slv_hresp = '0;
        for (int i = 0; i < NS; i++) slv_hrdata[32*i +: 32] = 32'hA5A5_0000 | i;
        slv_hrdata[32*10 +: 32] = 32'hDEAD_BEEF;

        // reset state
        tick(); tick();
        sample();
        chk("rst_hreadyout", {31'b0, rdy1}, 32'h1);
        chk("rst_hresp", {31'b0, resp1}, 32'h0);
        chk("rst_hrdata", rd1, 32'h0);
        chk("rst_err_valid", {31'b0, ev1}, 32'h0);
        chk("rst_err_addr", ea1, 32'h0);
        HSEL = 1'b1; HADDR = 32'h4000_A004; HTRANS = 2'b10;
        #1;
        chk("rst_hsel_comb", {21'b0, hsel1}, 32'h400);
        tick();
        HRESET = 1'b0;

        // slot 10 read
        sample();
        chk("s10_addr_hsel", {21'b0, hsel1}, 32'h400);
        chk("s10_addr_hrdata", rd1, 32'h0);
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        sample();
        chk("s10_hrdata", rd1, 32'hDEAD_BEEF);
        chk("s10_hresp", {31'b0, resp1}, 32'h0);
        chk("s10_hreadyout", {31'b0, rdy1}, 32'h1);
        chk("idle_hsel", {21'b0, hsel1}, 32'h0);

        // slot 11 out of range -> default slave
        tick();
        HSEL = 1'b1; HADDR = 32'h4000_B000; HTRANS = 2'b10;
        sample();
        chk("s11_hsel", {21'b0, hsel1}, 32'h0);
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        sample();
        chk("err1_hreadyout", {31'b0, rdy1}, 32'h0);
        chk("err1_hresp", {31'b0, resp1}, 32'h1);
        chk("err1_hrdata", rd1, 32'h0);
        chk("cap_err_valid", {31'b0, ev1}, 32'h1);
        chk("cap_err_addr", ea1, 32'h4000_B000);
        tick();
        sample();
        chk("err2_hreadyout", {31'b0, rdy1}, 32'h1);
        chk("err2_hresp", {31'b0, resp1}, 32'h1);
        tick();
        sample();
        chk("post_err_hresp", {31'b0, resp1}, 32'h0);
        chk("post_err_hreadyout", {31'b0, rdy1}, 32'h1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        sample();
        chk("clr_err_valid", {31'b0, ev1}, 32'h0);
        chk("clr_err_addr", ea1, 32'h0);

        // slot 3 stalls for three cycles while slot 4 address waits
        tick();
        HSEL = 1'b1; HADDR = 32'h4000_3000; HTRANS = 2'b10; slv_hreadyout[3] = 1'b0;
        tick();
        HADDR = 32'h4000_4000;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk($sformatf("stall%0d_hreadyout", c), {31'b0, rdy1}, 32'h0);
            chk($sformatf("stall%0d_hrdata", c), rd1, 32'hA5A5_0003);
            tick();
        end
        slv_hreadyout[3] = 1'b1;
        sample();
        chk("unstall_hreadyout", {31'b0, rdy1}, 32'h1);
        chk("unstall_hrdata", rd1, 32'hA5A5_0003);
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        sample();
        chk("s4_hrdata", rd1, 32'hA5A5_0004);

        // back-to-back unmapped NONSEQs
        tick();
        HSEL = 1'b1; HADDR = 32'h5000_0000; HTRANS = 2'b10;
        tick();
        HADDR = 32'h5000_0004;
        sample();
        chk("b2b_a_err1_rdy", {31'b0, rdy1}, 32'h0);
        chk("b2b_a_err1_resp", {31'b0, resp1}, 32'h1);
        tick();
        sample();
        chk("b2b_a_err2_rdy", {31'b0, rdy1}, 32'h1);
        chk("b2b_a_err2_resp", {31'b0, resp1}, 32'h1);
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        sample();
        chk("b2b_b_err1_rdy", {31'b0, rdy1}, 32'h0);
        chk("b2b_b_err1_resp", {31'b0, resp1}, 32'h1);
        tick();
        sample();
        chk("b2b_b_err2_rdy", {31'b0, rdy1}, 32'h1);
        chk("b2b_b_err2_resp", {31'b0, resp1}, 32'h1);
        tick();
        sample();
        chk("b2b_done_resp", {31'b0, resp1}, 32'h0);
        chk("b2b_err_addr", ea1, 32'h5000_0000);
        chk("b2b_err_valid", {31'b0, ev1}, 32'h1);

        // clear coinciding with a new error, then reset during ERR1
        tick();
        HSEL = 1'b1; HADDR = 32'h4000_C000; HTRANS = 2'b10; err_clr = 1'b1;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; err_clr = 1'b0; HRESET = 1'b1;
        sample();
        chk("clrcap_err_valid", {31'b0, ev1}, 32'h1);
        chk("clrcap_err_addr", ea1, 32'h4000_C000);
        chk("pre_rst_err1_rdy", {31'b0, rdy1}, 32'h0);
        tick();
        HRESET = 1'b0;
        sample();
        chk("rst_err1_hreadyout", {31'b0, rdy1}, 32'h1);
        chk("rst_err1_hresp", {31'b0, resp1}, 32'h0);
        chk("rst_err1_err_valid", {31'b0, ev1}, 32'h0);
        chk("rst_err1_err_addr", ea1, 32'h0);

        // slot 2 disabled: IDLE is OKAY, NONSEQ errors
        tick();
        HSEL = 1'b1; HADDR = 32'h4000_2000; HTRANS = 2'b00;
        sample();
        chk("en_hsel_dis", {21'b0, hsel2}, 32'h0);
        chk("en_hsel_ref", {21'b0, hsel1}, 32'h004);
        tick();
        HTRANS = 2'b10;
        sample();
        chk("en_idle_rdy", {31'b0, rdy2}, 32'h1);
        chk("en_idle_resp", {31'b0, resp2}, 32'h0);
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        sample();
        chk("en_err1_rdy", {31'b0, rdy2}, 32'h0);
        chk("en_err1_resp", {31'b0, resp2}, 32'h1);
        chk("en_err_addr", ea2, 32'h4000_2000);
        chk("en_ref_no_err", {31'b0, ev1}, 32'h0);
        tick();
        sample();
        chk("en_err2_rdy", {31'b0, rdy2}, 32'h1);
        chk("en_err2_resp", {31'b0, resp2}, 32'h1);
        tick();
        sample();
        chk("en_done_resp", {31'b0, resp2}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
